// File: rtl/q2_panel_ctrl_pkg.sv
// Shared definitions for the Q2 front-panel sequencer: state encodings,
// switch indices and default timing parameters.
package q2_panel_ctrl_pkg;

    localparam int DEFAULT_DB_BITS    = 4;
    localparam int DEFAULT_DEP_CYCLES = 3;
    localparam int DEP_CNT_W          = 4;
    localparam int NUM_SW             = 5;

    localparam int SW_START = 0;
    localparam int SW_STOP  = 1;
    localparam int SW_STEP  = 2;
    localparam int SW_DEP   = 3;
    localparam int SW_INCP  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STOPPING = 3'd2,
        ST_STEP     = 3'd3,
        ST_DEP      = 3'd4,
        ST_INCP     = 3'd5
    } panel_state_t;

endpackage

// File: rtl/q2_debounce.sv
// One console switch: 2-flop synchronizer, stability counter, debounced level
// and a single-cycle press pulse on the debounced 0->1 transition.
module q2_debounce #(
    parameter int DB_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic press
);

    logic               sync1;
    logic               sync2;
    logic               level;
    logic [DB_BITS-1:0] cnt;

    // The level flips only after 2^DB_BITS consecutive disagreeing samples;
    // the press pulse is issued on the same edge the level rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == '1) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + DB_BITS'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/q2_panel_ctrl.sv
// Q2 front-panel sequencer: debounced switch presses drive one FSM that
// sequences core clock enable, run/halt state, deposit strobes and P increments.
module q2_panel_ctrl
    import q2_panel_ctrl_pkg::*;
#(
    parameter int DB_BITS    = DEFAULT_DB_BITS,
    parameter int DEP_CYCLES = DEFAULT_DEP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start_sw,
    input  logic stop_sw,
    input  logic step_sw,
    input  logic dep_sw,
    input  logic incp_sw,
    input  logic halt,
    input  logic inst_done,
    output logic clk_en,
    output logic run,
    output logic dep,
    output logic incp,
    output logic halted,
    output logic busy
);

    logic [NUM_SW-1:0]    raw_sw;
    logic [NUM_SW-1:0]    press;
    panel_state_t         state;
    panel_state_t         next_state;
    logic [DEP_CNT_W-1:0] dep_cnt;
    logic                 set_halted;
    logic                 clr_halted;
    logic                 load_dep;

    assign raw_sw = {incp_sw, dep_sw, step_sw, stop_sw, start_sw};

    for (genvar i = 0; i < NUM_SW; i++) begin : g_db
        q2_debounce #(
            .DB_BITS (DB_BITS)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .sw    (raw_sw[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In IDLE a stop press outranks everything and does nothing itself, so
    // lower-priority presses landing in the same cycle are lost with it.
    always_comb begin
        next_state = state;
        set_halted = 1'b0;
        clr_halted = 1'b0;
        load_dep   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!press[SW_STOP] && !halt) begin
                    if (press[SW_START]) begin
                        next_state = ST_RUN;
                        clr_halted = 1'b1;
                    end else if (press[SW_STEP]) begin
                        next_state = ST_STEP;
                        clr_halted = 1'b1;
                    end else if (press[SW_DEP]) begin
                        next_state = ST_DEP;
                        load_dep   = 1'b1;
                    end else if (press[SW_INCP]) begin
                        next_state = ST_INCP;
                    end
                end
            end
            ST_RUN: begin
                if (halt) begin
                    next_state = ST_IDLE;
                    set_halted = 1'b1;
                end else if (press[SW_STOP]) begin
                    next_state = ST_STOPPING;
                end
            end
            ST_STOPPING, ST_STEP: begin
                if (halt) begin
                    next_state = ST_IDLE;
                    set_halted = 1'b1;
                end else if (inst_done) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DEP: begin
                if (dep_cnt <= DEP_CNT_W'(1)) begin
                    next_state = ST_INCP;
                end
            end
            ST_INCP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dep_cnt <= '0;
            halted  <= 1'b0;
        end else begin
            if (load_dep) begin
                dep_cnt <= DEP_CNT_W'(DEP_CYCLES);
            end else if (state == ST_DEP) begin
                dep_cnt <= dep_cnt - DEP_CNT_W'(1);
            end
            if (set_halted) begin
                halted <= 1'b1;
            end else if (clr_halted) begin
                halted <= 1'b0;
            end
        end
    end

    always_comb begin
        clk_en = 1'b0;
        run    = 1'b0;
        dep    = 1'b0;
        incp   = 1'b0;
        busy   = (state != ST_IDLE);
        case (state)
            ST_RUN: begin
                clk_en = 1'b1;
                run    = 1'b1;
            end
            ST_STOPPING: begin
                clk_en = 1'b1;
                run    = 1'b1;
            end
            ST_STEP: clk_en = 1'b1;
            ST_DEP:  dep    = 1'b1;
            ST_INCP: incp   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_q2_panel_ctrl.sv
// Directed bench for q2_panel_ctrl with DB_BITS=2 (press 6 cycles after a raw
// edge, FSM reacts in cycle 7) and DEP_CYCLES=3.
module tb_q2_panel_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start_sw, stop_sw, step_sw, dep_sw, incp_sw;
    logic halt, inst_done;
    logic clk_en, run, dep, incp, halted, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    q2_panel_ctrl #(
        .DB_BITS    (2),
        .DEP_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_sw  (start_sw),
        .stop_sw   (stop_sw),
        .step_sw   (step_sw),
        .dep_sw    (dep_sw),
        .incp_sw   (incp_sw),
        .halt      (halt),
        .inst_done (inst_done),
        .clk_en    (clk_en),
        .run       (run),
        .dep       (dep),
        .incp      (incp),
        .halted    (halted),
        .busy      (busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // sw = {incp, dep, step, stop, start}
    task automatic apply_stimulus(input logic [4:0] sw);
        {incp_sw, dep_sw, step_sw, stop_sw, start_sw} = sw;
    endtask

    task automatic check_output(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_clk_en"}, clk_en, 1'b0);
        check_output({tag, "_run"},    run,    1'b0);
        check_output({tag, "_dep"},    dep,    1'b0);
        check_output({tag, "_incp"},   incp,   1'b0);
        check_output({tag, "_halted"}, halted, 1'b0);
        check_output({tag, "_busy"},   busy,   1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        halt      = 1'b0;
        inst_done = 1'b0;
        apply_stimulus(5'b00000);
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Bouncing deposit switch never settles long enough to count
        for (int i = 0; i < 10; i++) begin
            apply_stimulus((i % 2 == 0) ? 5'b01000 : 5'b00000);
            tick(2);
            check_output($sformatf("bounce_dep_%0d", i), dep, 1'b0);
            check_output($sformatf("bounce_busy_%0d", i), busy, 1'b0);
        end
        apply_stimulus(5'b00000);
        tick(8);

        // Held deposit: dep cycles 7-9, incp cycle 10, busy 7-10
        apply_stimulus(5'b01000);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check_output($sformatf("hold_dep_c%0d", k),  dep,  (k >= 7 && k <= 9));
            check_output($sformatf("hold_incp_c%0d", k), incp, (k == 10));
            check_output($sformatf("hold_busy_c%0d", k), busy, (k >= 7 && k <= 10));
        end
        tick(10);
        check_output("hold_single_press", busy, 1'b0);
        apply_stimulus(5'b00000);
        tick(8);

        // Start, then stop waits for instruction boundary
        apply_stimulus(5'b00001);
        tick(6);
        check_output("start_c6_run", run, 1'b0);
        tick(1);
        check_output("start_c7_run", run, 1'b1);
        check_output("start_c7_clk_en", clk_en, 1'b1);
        apply_stimulus(5'b00000);
        tick(8);
        apply_stimulus(5'b00010);
        tick(10);
        check_output("stopping_run", run, 1'b1);
        check_output("stopping_clk_en", clk_en, 1'b1);
        inst_done = 1'b1;
        tick(1);
        inst_done = 1'b0;
        check_output("stop_done_clk_en", clk_en, 1'b0);
        check_output("stop_done_run", run, 1'b0);
        check_output("stop_done_halted", halted, 1'b0);
        check_output("stop_done_busy", busy, 1'b0);
        apply_stimulus(5'b00000);
        tick(8);

        // Halt in RUN, presses ignored while halted, start clears halted
        apply_stimulus(5'b00001);
        tick(7);
        check_output("run2_run", run, 1'b1);
        apply_stimulus(5'b00000);
        halt = 1'b1;
        tick(1);
        check_output("halt_clk_en", clk_en, 1'b0);
        check_output("halt_halted", halted, 1'b1);
        apply_stimulus(5'b10000);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check_output($sformatf("halt_incp_c%0d", k), incp, 1'b0);
        end
        check_output("halt_ignored_busy", busy, 1'b0);
        apply_stimulus(5'b00000);
        tick(8);
        halt = 1'b0;
        tick(1);
        check_output("halted_sticky", halted, 1'b1);
        apply_stimulus(5'b00001);
        tick(6);
        check_output("restart_c6_halted", halted, 1'b1);
        tick(1);
        check_output("restart_c7_halted", halted, 1'b0);
        check_output("restart_c7_run", run, 1'b1);
        apply_stimulus(5'b00000);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check_output("halt2_run", run, 1'b0);
        check_output("halt2_halted", halted, 1'b1);
        tick(8);

        // Start and deposit together: start wins; step in RUN dropped
        apply_stimulus(5'b01001);
        tick(7);
        check_output("both_run", run, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            check_output($sformatf("both_dep_%0d", k), dep, 1'b0);
        end
        apply_stimulus(5'b01101);
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check_output($sformatf("run_step_run_%0d", k), run, 1'b1);
            check_output($sformatf("run_step_dep_%0d", k), dep, 1'b0);
        end
        apply_stimulus(5'b00000);
        tick(8);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check_output("exit_run_busy", busy, 1'b0);

        // Step: inst_done 5 cycles after entry gives 6 cycles of clk_en
        apply_stimulus(5'b00100);
        tick(6);
        check_output("step_c6_clk_en", clk_en, 1'b0);
        check_output("step_c6_halted", halted, 1'b1);
        tick(1);
        check_output("step_c7_clk_en", clk_en, 1'b1);
        check_output("step_c7_run", run, 1'b0);
        check_output("step_c7_halted", halted, 1'b0);
        for (int k = 8; k <= 12; k++) begin
            tick(1);
            check_output($sformatf("step_c%0d_clk_en", k), clk_en, 1'b1);
        end
        inst_done = 1'b1;
        tick(1);
        inst_done = 1'b0;
        check_output("step_c13_clk_en", clk_en, 1'b0);
        check_output("step_c13_busy", busy, 1'b0);
        apply_stimulus(5'b00000);
        tick(8);

        // Reset during second deposit cycle aborts without incp
        apply_stimulus(5'b01000);
        tick(7);
        check_output("abort_c7_dep", dep, 1'b1);
        tick(1);
        check_output("abort_c8_dep", dep, 1'b1);
        rst = 1'b1;
        apply_stimulus(5'b00000);
        tick(1);
        check_all_zero("abort_reset");
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check_output($sformatf("abort_incp_%0d", k), incp, 1'b0);
            check_output($sformatf("abort_busy_%0d", k), busy, 1'b0);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
